// File: rtl/jam_cost_server.sv
// Responder side of the JAM worker/job cost interface: serially loaded 8x8 cost table,
// zero-latency cost lookup while serving, result capture and serve-cycle counting.
module jam_cost_server #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int CNT_W  = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_valid,
    input  logic [COST_W-1:0] load_data,
    output logic              load_ready,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [9:0]        MinCost,
    input  logic [3:0]        MatchCount,
    output logic              done,
    output logic [9:0]        res_min,
    output logic [3:0]        res_match,
    output logic [CNT_W-1:0]  serve_cnt,
    output logic              proto_err
);

    localparam int DEPTH = N * N;
    localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD,
        SERVE,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [5:0]        load_idx;
    logic              accept;
    logic              capture;
    logic [COST_W-1:0] cost_table [DEPTH];

    always_comb begin
        next_state = state;
        load_ready = 1'b0;
        Cost       = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            LOAD: begin
                load_ready = 1'b1;
                accept     = load_valid;
                if (load_valid && load_idx == LAST_IDX)
                    next_state = SERVE;
            end
            SERVE: begin
                Cost = cost_table[{W, J}];
                if (Valid) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                load_ready = 1'b1;
                accept     = load_valid;
                if (load_valid)
                    next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
    end

    assign done = (state == DONE);

    // A load accepted in DONE restarts the table at entry 0, so the next entry goes to index 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= LOAD;
            load_idx  <= '0;
            res_min   <= '0;
            res_match <= '0;
            serve_cnt <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= next_state;
            if (accept)
                load_idx <= (state == DONE) ? 6'd1 : load_idx + 6'd1;
            if (state == SERVE && serve_cnt != '1)
                serve_cnt <= serve_cnt + 1'b1;
            if (state == DONE && accept)
                serve_cnt <= '0;
            if (capture) begin
                res_min   <= MinCost;
                res_match <= MatchCount;
            end
            if (Valid && state != SERVE)
                proto_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && accept)
            cost_table[(state == DONE) ? 6'd0 : load_idx] <= load_data;
    end

endmodule
